// File: rtl/e_mdu_pkg.sv
// rtl/e_mdu_pkg.sv - shared MDU operation encodings and latency defaults
//
// Purpose: operation codes and default latencies shared by the E-stage
//          decode, the hazard unit and the multiply/divide unit.
// Contents:
//   md_op_e          - 4-bit md_op encoding
//   mdu_state_e      - MDU control states
//   MULT_CYCLES_DEF  - default busy length for mult/multu
//   DIV_CYCLES_DEF   - default busy length for div/divu
//   is_md_start_op   - true for ops that launch a timed operation
//   is_md_div_op     - true for div/divu
package e_mdu_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic is_md_start_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_md_div_op(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_calc.sv
// rtl/e_mdu_calc.sv - combinational product and quotient/remainder generator
//
// Purpose: produces the HI/LO pair an operation will commit, plus a
//          divide-by-zero flag.
// Ports:
//   i_op        in  4   operation code (md_op_e encoding)
//   i_a         in  32  rs operand (dividend / multiplicand)
//   i_b         in  32  rt operand (divisor / multiplier)
//   o_hi        out 32  high product word or remainder
//   o_lo        out 32  low product word or quotient
//   o_div_zero  out 1   divisor is zero
module e_mdu_calc
  import e_mdu_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_div_zero
);

  logic signed [63:0] w_sprod;
  logic        [63:0] w_uprod;
  logic               w_signed_div;
  logic               w_a_neg;
  logic               w_b_neg;
  logic        [31:0] w_a_mag;
  logic        [31:0] w_b_mag;
  logic        [31:0] w_dvd;
  logic        [31:0] w_dvs;
  logic        [31:0] w_q;
  logic        [31:0] w_r;
  logic        [31:0] w_quot;
  logic        [31:0] w_rem;

  assign w_sprod = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
  assign w_uprod = {32'b0, i_a} * {32'b0, i_b};

  assign o_div_zero = (i_b == 32'd0);

  // One unsigned divider serves both div and divu: signed division runs on
  // magnitudes and the signs are restored afterwards. This also makes
  // 0x80000000 / -1 fall out naturally as quotient 0x80000000, remainder 0.
  assign w_signed_div = (i_op == MD_DIV);
  assign w_a_neg      = w_signed_div & i_a[31];
  assign w_b_neg      = w_signed_div & i_b[31];
  assign w_a_mag      = w_a_neg ? (32'd0 - i_a) : i_a;
  assign w_b_mag      = w_b_neg ? (32'd0 - i_b) : i_b;
  assign w_dvd        = w_a_mag;
  // A zero divisor is replaced by 1 so the divider never sees x/0; the
  // result is discarded at commit anyway.
  assign w_dvs        = o_div_zero ? 32'd1 : w_b_mag;
  assign w_q          = w_dvd / w_dvs;
  assign w_r          = w_dvd % w_dvs;
  assign w_quot       = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q) : w_q;
  assign w_rem        = w_a_neg ? (32'd0 - w_r) : w_r;

  always_comb begin
    o_hi = 32'd0;
    o_lo = 32'd0;
    case (i_op)
      MD_MULT: begin
        o_hi = w_sprod[63:32];
        o_lo = w_sprod[31:0];
      end
      MD_MULTU: begin
        o_hi = w_uprod[63:32];
        o_lo = w_uprod[31:0];
      end
      MD_DIV, MD_DIVU: begin
        o_hi = w_rem;
        o_lo = w_quot;
      end
      default: begin
        o_hi = 32'd0;
        o_lo = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - E-stage multiply/divide unit with start/busy handshake
//
// Purpose: accepts a one-cycle start for mult/multu/div/divu, holds busy
//          for a fixed latency, then commits the result to HI/LO. mthi/mtlo
//          write HI/LO directly when the unit is not busy.
// Ports:
//   clk    in  1   system clock, rising edge
//   reset  in  1   asynchronous active-low reset
//   start  in  1   operation-issue strobe (mult/multu/div/divu)
//   md_op  in  4   operation code (md_op_e encoding)
//   A      in  32  rs operand
//   B      in  32  rt operand
//   busy   out 1   operation in flight
//   HI     out 32  HI register
//   LO     out 32  LO register
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_e         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_pend_hi;
  logic [31:0]        r_pend_lo;
  logic               r_pend_dz;
  logic               r_busy;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;

  logic [31:0]        w_calc_hi;
  logic [31:0]        w_calc_lo;
  logic               w_div_zero;
  logic               w_launch;

  e_mdu_calc u_calc (
    .i_op       (md_op),
    .i_a        (A),
    .i_b        (B),
    .o_hi       (w_calc_hi),
    .o_lo       (w_calc_lo),
    .o_div_zero (w_div_zero)
  );

  assign w_launch = start & is_md_start_op(md_op);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_pend_dz <= 1'b0;
      r_busy    <= 1'b0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_launch) begin
            // The result is captured at issue so later operand changes
            // (the pipeline moves on while stalled) cannot disturb it.
            r_pend_hi <= w_calc_hi;
            r_pend_lo <= w_calc_lo;
            r_pend_dz <= w_div_zero & is_md_div_op(md_op);
            r_cnt     <= is_md_div_op(md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            r_state   <= ST_RUN;
            r_busy    <= 1'b1;
          end
          if (md_op == MD_MTHI) r_hi <= A;
          if (md_op == MD_MTLO) r_lo <= A;
        end
        ST_RUN: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            if (!r_pend_dz) begin
              r_hi <= r_pend_hi;
              r_lo <= r_pend_lo;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_e_mdu.sv
// tb/tb_e_mdu.sv - self-checking bench for e_mdu
module tb_e_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .md_op (md_op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  bit          p_dz;
  int          remain;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_hi = 32'd0; m_lo = 32'd0; p_hi = 32'd0; p_lo = 32'd0; p_dz = 1'b0; remain = 0;
  endtask

  task automatic model_edge();
    longint sa, sb, sp, sq, sr;
    logic [63:0] up;
    if (reset !== 1'b1) return;
    if (remain > 0) begin
      remain--;
      if (remain == 0 && !p_dz) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end else begin
      if (start && md_op >= 4'd1 && md_op <= 4'd4) begin
        sa = $signed(A);
        sb = $signed(B);
        p_dz = (md_op >= 4'd3) && (B == 32'd0);
        case (md_op)
          4'd1: begin sp = sa * sb; p_hi = sp[63:32]; p_lo = sp[31:0]; end
          4'd2: begin up = {32'd0, A} * {32'd0, B}; p_hi = up[63:32]; p_lo = up[31:0]; end
          4'd3: if (B != 32'd0) begin
            sq = sa / sb; sr = sa % sb; p_lo = sq[31:0]; p_hi = sr[31:0];
          end
          default: if (B != 32'd0) begin p_lo = A / B; p_hi = A % B; end
        endcase
        remain = (md_op <= 4'd2) ? 5 : 10;
      end
      if (md_op == 4'd5) m_hi = A;
      if (md_op == 4'd6) m_lo = A;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(remain > 0));
      chk("HI", HI, m_hi);
      chk("LO", LO, m_lo);
    end
  end

  task automatic tick(input bit st, input logic [3:0] op, input logic [31:0] ia, input logic [31:0] ib);
    start = st; md_op = op; A = ia; B = ib;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      tick(1'b0, 4'd0, 32'd0, 32'd0);
    end
  endtask

  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] ia,
                        input logic [31:0] ib, input int exp_n,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    tick(1'b1, op, ia, ib);
    wait_idle(n);
    chk({name, "_cycles"}, 32'(n), 32'(exp_n));
    chk({name, "_hi"}, HI, exp_hi);
    chk({name, "_lo"}, LO, exp_lo);
  endtask

  initial begin
    int n;
    reset = 1'b0; start = 1'b0; md_op = 4'd0; A = 32'd0; B = 32'd0;
    model_reset();
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk_en = 1'b1;
    @(negedge clk);
    repeat (3) tick(1'b0, 4'd0, 32'd0, 32'd0);

    run_op("mult",  4'd1, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu", 4'd2, 32'hFFFFFFFE, 32'd3, 5, 32'h00000002, 32'hFFFFFFFA);
    run_op("div",   4'd3, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);

    tick(1'b0, 4'd5, 32'h11, 32'd0);
    tick(1'b0, 4'd6, 32'h22, 32'd0);
    run_op("divu_dz", 4'd4, 32'd7, 32'd0, 10, 32'h11, 32'h22);

    tick(1'b0, 4'd5, 32'h12345678, 32'd0);
    chk("mthi", HI, 32'h12345678);

    // mtlo while busy must be ignored
    tick(1'b1, 4'd3, 32'd100, 32'd7);
    tick(1'b0, 4'd6, 32'h0000AAAA, 32'd0);
    wait_idle(n);
    chk("mtlo_busy_cycles", 32'(n + 1), 32'd10);
    chk("mtlo_busy_hi", HI, 32'd2);
    chk("mtlo_busy_lo", LO, 32'd14);

    // start of a mult in busy cycle 3 must be ignored
    tick(1'b1, 4'd3, 32'd1000, 32'd7);
    tick(1'b0, 4'd0, 32'd0, 32'd0);
    tick(1'b0, 4'd0, 32'd0, 32'd0);
    tick(1'b1, 4'd1, 32'd9, 32'd9);
    wait_idle(n);
    chk("start_busy_cycles", 32'(n + 3), 32'd10);
    chk("start_busy_hi", HI, 32'd6);
    chk("start_busy_lo", LO, 32'd142);

    // asynchronous reset in busy cycle 4 discards the in-flight divide
    tick(1'b1, 4'd3, 32'd1000, 32'd7);
    repeat (3) tick(1'b0, 4'd0, 32'd0, 32'd0);
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_hi", HI, 32'd0);
    chk("async_rst_lo", LO, 32'd0);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    repeat (15) tick(1'b0, 4'd0, 32'd0, 32'd0);
    chk("no_commit_hi", HI, 32'd0);
    chk("no_commit_lo", LO, 32'd0);

    // randomized traffic, checked every cycle by the model
    for (int i = 0; i < 300; i++) begin
      logic [31:0] ra, rb;
      logic [3:0]  rop;
      rop = 4'($urandom_range(0, 8));
      ra  = $urandom();
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 :
            ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 20)) : $urandom();
      if ($urandom_range(0, 3) == 0) ra = {$urandom_range(0, 1) == 0 ? 1'b1 : 1'b0, 31'd0};
      tick(1'($urandom_range(0, 1)), rop, ra, rb);
    end
    repeat (12) tick(1'b0, 4'd0, 32'd0, 32'd0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Multiply/divide unit in the E stage. It is the responder for the start/BUSY handshake that the E-stage pipeline register and the hazard unit consume.
- Accepts a one-cycle start with an operation code and two operands. Holds busy for a fixed latency, then commits results to the HI/LO registers.
- HI/LO are read combinationally for mfhi/mflo.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- start  in  1  operation-issue strobe from E-stage decode; valid for mult/multu/div/divu only
- md_op  in  4  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, others none
- A  in  32  rs operand (dividend / multiplicand / mthi-mtlo source)
- B  in  32  rt operand (divisor / multiplier)
- busy  out  1  operation in flight
- HI  out  32  HI register
- LO  out  32  LO register

Behaviour:
- Reset (reset=0, asynchronous): busy=0, HI=0, LO=0, counter=0, pending results=0. Takes effect immediately, including mid-operation; the in-flight result is discarded and never committed.
- States: IDLE, RUN.
- IDLE, start=1, md_op in {1..4}, at edge T:
  - A/B latched; result computed into pending_hi/pending_lo.
  - counter loaded with MULT_CYCLES or DIV_CYCLES.
  - move to RUN; busy=1 from T+ (first cycle after edge T).
- RUN, each edge: counter decrements.
  - At the edge where counter goes 1→0: HI/LO <= pending, busy <= 0, state back to IDLE.
  - busy is therefore high for exactly N cycles after the start edge. New HI/LO are visible in the same cycle busy falls.
- start while busy=1: ignored, because the hazard unit stalls. Operands and result of the in-flight op are unaffected.
- start with md_op not in {1..4}: ignored (no busy).
- mthi (5) / mtlo (6): write HI/LO from A at the next edge, independent of start, no busy.
  - Accepted only when busy=0; ignored while busy.
- mult: {HI,LO} = signed A × signed B (64-bit). multu: unsigned product.
- div: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned quotient and remainder.
- Divide by zero (B=0) for div/divu: busy sequence still runs for DIV_CYCLES; HI/LO are left unchanged at commit.
- HI/LO outputs are direct register values with no bypass. mfhi/mflo issued in a cycle with busy=1 are stalled externally.

Decomposition:
- Shared package/header: MD_OP encodings (MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO) and the default latency constants. The E-stage decode and the hazard unit use the same definitions.
- One natural sub-module: e_mdu_calc, a combinational 64-bit product and quotient/remainder generator, including the divide-by-zero flag.
- Counter, FSM and HI/LO registers stay in e_mdu.

Test Plan:
- Reset release, then idle 3 cycles → busy=0, HI=0, LO=0 throughout.
- start, mult, A=0xFFFFFFFE (−2), B=3 → busy=1 for exactly 5 cycles. On busy fall: HI=0xFFFFFFFF, LO=0xFFFFFFFA. Same operands with multu → HI=0x00000002, LO=0xFFFFFFFA.
- start, div, A=0xFFFFFFF9 (−7), B=2 → busy=1 for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu, A=7, B=0 with HI=0x11, LO=0x22 beforehand → busy for 10 cycles, HI/LO still 0x11/0x22.
- mthi A=0x12345678 with busy=0 → HI=0x12345678 next cycle.
  - Issue div, then mtlo A=0xAAAA while busy → LO ignored, LO gets the quotient at commit.
- div started; start with mult in cycle 3 of busy → ignored. busy still falls after 10 total cycles with the div results.
- div started; reset pulsed low in busy cycle 4 → busy, HI, LO go to 0 immediately (before the next edge). No commit occurs after reset release.
